pb_debounce: RTL and testbench

PB_DEBOUNCE -- requirements
Module: pb_debounce

---
 rtl/pb_debounce.sv | 144 ++++++++++++++
 tb/tb_pb_debounce.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pb_debounce.sv
// Two-channel push-button conditioner: synchronizer, debounce FSM, press pulse
// and stuck-button detector for the left and right buttons.
module pb_debounce #(
  parameter int unsigned DEB_CNT = 50000,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned STUCK_W = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic pbl_raw,
  input  logic pbr_raw,
  output logic pbl,
  output logic pbr,
  output logic pbl_press,
  output logic pbr_press,
  output logic stuck_l,
  output logic stuck_r
);

  // Counter value on which the next disagreeing sample completes a debounce
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    HIGH = 2'd2,
    FALL = 2'd3
  } state_t;

  logic [1:0] raw;
  logic [1:0] level_v;
  logic [1:0] press_v;
  logic [1:0] stuck_v;

  assign raw = {pbr_raw, pbl_raw};

  for (genvar i = 0; i < 2; i++) begin : g_chan
    state_t             state;
    logic               s1;
    logic               s2;
    logic [CNT_W-1:0]   cnt;
    logic [STUCK_W-1:0] hold;
    logic               level;
    logic               press;
    logic               stuck;
    logic               done_c;
    logic               fall_c;

    // A disagreeing sample that lands on the last count toggles the level
    always_comb begin
      done_c = 1'b0;
      fall_c = 1'b0;
      if ((s2 != level) && (cnt == CNT_LAST)) begin
        done_c = 1'b1;
        fall_c = level;
      end
    end

    // Two-flop synchronizer for the raw button
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= raw[i];
        s2 <= s1;
      end
    end

    // Debounce FSM with registered level and press pulse
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        cnt   <= '0;
        level <= 1'b0;
        press <= 1'b0;
      end else begin
        press <= 1'b0;
        case (state)
          IDLE, RISE: begin
            if (!s2) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (done_c) begin
              state <= HIGH;
              cnt   <= '0;
              level <= 1'b1;
              press <= 1'b1;
            end else begin
              state <= RISE;
              cnt   <= cnt + CNT_W'(1);
            end
          end
          HIGH, FALL: begin
            if (s2) begin
              state <= HIGH;
              cnt   <= '0;
            end else if (done_c) begin
              state <= IDLE;
              cnt   <= '0;
              level <= 1'b0;
            end else begin
              state <= FALL;
              cnt   <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
          end
        endcase
      end
    end

    // Hold counter saturates while pressed; stuck mirrors the saturated state
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold  <= '0;
        stuck <= 1'b0;
      end else if (fall_c || !level) begin
        hold  <= '0;
        stuck <= 1'b0;
      end else if (hold != '1) begin
        hold  <= hold + STUCK_W'(1);
        stuck <= ((hold + STUCK_W'(1)) == '1);
      end else begin
        stuck <= 1'b1;
      end
    end

    assign level_v[i] = level;
    assign press_v[i] = press;
    assign stuck_v[i] = stuck;
  end

  assign pbl       = level_v[0];
  assign pbr       = level_v[1];
  assign pbl_press = press_v[0];
  assign pbr_press = press_v[1];
  assign stuck_l   = stuck_v[0];
  assign stuck_r   = stuck_v[1];

endmodule

// File: tb/tb_pb_debounce.sv
// Directed bench for pb_debounce with DEB_CNT=4, STUCK_W=4. Expected output
// vectors {stuck_r, stuck_l, pbr_press, pbl_press, pbr, pbl} are queued per
// cycle as stimulus is driven and compared after each rising edge.
module tb_pb_debounce;

  logic clk = 1'b0;
  logic rst;
  logic pbl_raw;
  logic pbr_raw;
  logic pbl;
  logic pbr;
  logic pbl_press;
  logic pbr_press;
  logic stuck_l;
  logic stuck_r;

  pb_debounce #(
    .DEB_CNT(4),
    .CNT_W  (16),
    .STUCK_W(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pbl_raw  (pbl_raw),
    .pbr_raw  (pbr_raw),
    .pbl      (pbl),
    .pbr      (pbr),
    .pbl_press(pbl_press),
    .pbr_press(pbr_press),
    .stuck_l  (stuck_l),
    .stuck_r  (stuck_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        cyc;
    logic [5:0] vec;
    string     tag;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   b;

  function automatic logic [5:0] obs();
    return {stuck_r, stuck_l, pbr_press, pbl_press, pbr, pbl};
  endfunction

  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] o;
    o = obs();
    total++;
    assert (o === exp)
    else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, o, exp);
    end
  endtask

  task automatic expect_at(input int c, input logic [5:0] v, input string tag);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic expect_range(input int c0, input int c1, input logic [5:0] v, input string tag);
    for (int c = c0; c <= c1; c++) expect_at(c, v, tag);
  endtask

  // Advance n edges, comparing every queued expectation that is due
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc == cyc) begin
          check(q[i].tag, q[i].vec);
          q.delete(i);
        end
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    pbl_raw = 1'b0;
    pbr_raw = 1'b0;
    #3;
    check("reset_state", 6'b000000);
    run(2);
    rst = 1'b0;

    // Clean left press
    b = cyc;
    pbl_raw = 1'b1;
    expect_range(b + 1, b + 5, 6'b000000, "press_wait");
    expect_at(b + 6, 6'b000101, "press_edge");
    expect_range(b + 7, b + 9, 6'b000001, "press_hold");
    run(9);

    // Two-cycle low glitch while held keeps the level
    b = cyc;
    pbl_raw = 1'b0;
    expect_range(b + 1, b + 6, 6'b000001, "glitch_held");
    run(2);
    pbl_raw = 1'b1;
    run(4);

    // Release: level falls at edge 6, no pulse
    b = cyc;
    pbl_raw = 1'b0;
    expect_range(b + 1, b + 5, 6'b000001, "release_wait");
    expect_range(b + 6, b + 9, 6'b000000, "release_done");
    run(9);

    // Bounce: high 3, low 1, then high
    b = cyc;
    pbl_raw = 1'b1;
    expect_range(b + 1, b + 9, 6'b000000, "bounce_quiet");
    expect_at(b + 10, 6'b000101, "bounce_press");
    expect_range(b + 11, b + 12, 6'b000001, "bounce_hold");
    run(3);
    pbl_raw = 1'b0;
    run(1);
    pbl_raw = 1'b1;
    run(8);
    b = cyc;
    pbl_raw = 1'b0;
    expect_range(b + 1, b + 5, 6'b000001, "bounce_rel_wait");
    expect_range(b + 6, b + 7, 6'b000000, "bounce_rel_done");
    run(7);

    // Simultaneous press, left released early, right held until stuck
    b = cyc;
    pbl_raw = 1'b1;
    pbr_raw = 1'b1;
    expect_range(b + 1, b + 5, 6'b000000, "simul_wait");
    expect_at(b + 6, 6'b001111, "simul_press");
    expect_range(b + 7, b + 12, 6'b000011, "simul_hold");
    expect_range(b + 13, b + 20, 6'b000010, "right_only");
    expect_range(b + 21, b + 29, 6'b100010, "stuck_r");
    expect_at(b + 30, 6'b000000, "stuck_clear");
    run(7);
    pbl_raw = 1'b0;
    run(17);
    pbr_raw = 1'b0;
    run(7);

    // Reset mid-count, then re-debounce with the button still held
    b = cyc;
    pbl_raw = 1'b1;
    expect_range(b + 1, b + 4, 6'b000000, "pre_reset");
    run(4);
    rst = 1'b1;
    #2;
    check("reset_midcount", 6'b000000);
    run(1);
    rst = 1'b0;
    b = cyc;
    expect_range(b + 1, b + 5, 6'b000000, "rerun_wait");
    expect_at(b + 6, 6'b000101, "rerun_press");
    run(6);

    // Reset mid-pulse clears outputs without a clock edge
    rst = 1'b1;
    #2;
    check("reset_midpulse", 6'b000000);
    run(1);
    rst = 1'b0;
    b = cyc;
    expect_range(b + 1, b + 5, 6'b000000, "rerun2_wait");
    expect_at(b + 6, 6'b000101, "rerun2_press");
    expect_at(b + 7, 6'b000001, "rerun2_hold");
    run(7);

    // Anything left in the queue was never compared
    total++;
    assert (q.size() == 0)
    else begin
      bad++;
      $error("FAIL queue_drain observed=%0d expected=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
